// File: rtl/id_ex_stage_pkg.sv
// Shared types and helpers for the ID->EX pipeline register: register-index
// width, operand-source bit positions, alu operation codes and control bundle.
package id_ex_stage_pkg;

  localparam int REG_W      = 5;
  localparam int ID_SRC_IMM = 0;
  localparam int ID_SRC_PC  = 1;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [1:0]       src;
    logic             wb_en;
    logic             is_load;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_IDLE = '{
    valid:   1'b0,
    rd:      5'd0,
    rs1:     5'd0,
    rs2:     5'd0,
    src:     2'd0,
    wb_en:   1'b0,
    is_load: 1'b0
  };

  // x0 never matches: it is hard-wired to zero
  function automatic logic reg_hit(input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rd,
                                   input logic             en);
    return en && (rd == rs) && (rs != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source register: MEM result beats WB data,
// which beats the registered raw operand; x0 always reads as zero.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  raw,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb_en,
  input  logic [XLEN-1:0]  mem_res,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_en,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  fwd
);

  // Priority select of the youngest producer of rs
  always_comb begin
    fwd = raw;
    if (rs == {REG_W{1'b0}}) begin
      fwd = {XLEN{1'b0}};
    end else if (reg_hit(rs, mem_rd, mem_wb_en)) begin
      fwd = mem_res;
    end else if (reg_hit(rs, wb_rd, wb_en)) begin
      fwd = wb_data;
    end else begin
      fwd = raw;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register feeding the alu: captures decoded ops, forwards from
// MEM/WB, selects pc/imm sources, and inserts load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_alu_op,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [1:0]       id_src,
  input  logic             id_is_load,
  input  logic             id_wb_en,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb_en,
  input  logic [XLEN-1:0]  mem_res,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_en,
  input  logic [XLEN-1:0]  wb_data,
  output logic             id_ready,
  output logic             ex_valid,
  output logic [OP_W-1:0]  ex_alu_op,
  output logic [XLEN-1:0]  ex_r1,
  output logic [XLEN-1:0]  ex_r2,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_wb_en,
  output logic             ex_is_load
);

  ex_ctrl_t        ctrl_r;
  logic [OP_W-1:0] alu_op_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] raw1_r;
  logic [XLEN-1:0] raw2_r;
  logic [XLEN-1:0] cap1_s;
  logic [XLEN-1:0] cap2_s;
  logic [XLEN-1:0] fwd1_s;
  logic [XLEN-1:0] fwd2_s;
  logic            hazard_s;

  // Load in EX produces a register the decoding instruction names
  always_comb begin
    if (id_valid && ctrl_r.valid && ctrl_r.is_load &&
        (ctrl_r.rd != {REG_W{1'b0}}) &&
        ((ctrl_r.rd == id_rs1) || (ctrl_r.rd == id_rs2))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign id_ready = ex_ready & ~hazard_s;

  // Regfile read races the WB write in the same cycle, so bypass WB at capture
  always_comb begin
    if (id_rs1 == {REG_W{1'b0}}) begin
      cap1_s = {XLEN{1'b0}};
    end else if (reg_hit(id_rs1, wb_rd, wb_en)) begin
      cap1_s = wb_data;
    end else begin
      cap1_s = id_rs1_data;
    end
    if (id_rs2 == {REG_W{1'b0}}) begin
      cap2_s = {XLEN{1'b0}};
    end else if (reg_hit(id_rs2, wb_rd, wb_en)) begin
      cap2_s = wb_data;
    end else begin
      cap2_s = id_rs2_data;
    end
  end

  // Pipeline register: reset, stall, bubble, capture in that priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r   <= EX_CTRL_IDLE;
      alu_op_r <= {OP_W{1'b0}};
      imm_r    <= {XLEN{1'b0}};
      pc_r     <= {XLEN{1'b0}};
      raw1_r   <= {XLEN{1'b0}};
      raw2_r   <= {XLEN{1'b0}};
    end else if (!ex_ready) begin
      // Producers keep retiring while stalled; absorb them so they are not lost
      raw1_r <= fwd1_s;
      raw2_r <= fwd2_s;
    end else if (flush || hazard_s || !id_valid) begin
      ctrl_r.valid   <= 1'b0;
      ctrl_r.wb_en   <= 1'b0;
      ctrl_r.is_load <= 1'b0;
    end else begin
      ctrl_r.valid   <= 1'b1;
      ctrl_r.rd      <= id_rd;
      ctrl_r.rs1     <= id_rs1;
      ctrl_r.rs2     <= id_rs2;
      ctrl_r.src     <= id_src;
      ctrl_r.wb_en   <= id_wb_en;
      ctrl_r.is_load <= id_is_load;
      alu_op_r       <= id_alu_op;
      imm_r          <= id_imm;
      pc_r           <= id_pc;
      raw1_r         <= cap1_s;
      raw2_r         <= cap2_s;
    end
  end

  id_ex_stage_fwd_mux #(.XLEN(XLEN)) u_fwd1 (
    .rs        (ctrl_r.rs1),
    .raw       (raw1_r),
    .mem_rd    (mem_rd),
    .mem_wb_en (mem_wb_en),
    .mem_res   (mem_res),
    .wb_rd     (wb_rd),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .fwd       (fwd1_s)
  );

  id_ex_stage_fwd_mux #(.XLEN(XLEN)) u_fwd2 (
    .rs        (ctrl_r.rs2),
    .raw       (raw2_r),
    .mem_rd    (mem_rd),
    .mem_wb_en (mem_wb_en),
    .mem_res   (mem_res),
    .wb_rd     (wb_rd),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .fwd       (fwd2_s)
  );

  assign ex_valid      = ctrl_r.valid;
  assign ex_alu_op     = alu_op_r;
  assign ex_rd         = ctrl_r.rd;
  assign ex_r1         = ctrl_r.src[ID_SRC_PC]  ? pc_r  : fwd1_s;
  assign ex_r2         = ctrl_r.src[ID_SRC_IMM] ? imm_r : fwd2_s;
  assign ex_store_data = fwd2_s;
  assign ex_wb_en      = ctrl_r.valid & ctrl_r.wb_en;
  assign ex_is_load    = ctrl_r.valid & ctrl_r.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with scoreboard queue,
// plus hand-written reset, load-use, stall, flush and reset-in-stall sequences.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_alu_op, id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_alu_op, ex_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, mem_res, wb_data;
  logic [1:0]  id_src;
  logic        id_is_load, id_wb_en, flush, ex_ready, mem_wb_en, wb_en;
  logic        id_ready, ex_valid, ex_wb_en, ex_is_load;
  logic [31:0] ex_r1, ex_r2, ex_store_data;

  int n_total = 0;
  int n_pass  = 0;

  id_ex_stage #(.XLEN(32), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_src(id_src),
    .id_is_load(id_is_load), .id_wb_en(id_wb_en), .flush(flush),
    .ex_ready(ex_ready), .mem_rd(mem_rd), .mem_wb_en(mem_wb_en),
    .mem_res(mem_res), .wb_rd(wb_rd), .wb_en(wb_en), .wb_data(wb_data),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op, rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [1:0]  src;
    logic        ld, we;
    logic        cwe;  logic [4:0] crd; logic [31:0] cdata;  // WB during capture
    logic        mwe;  logic [4:0] mrd; logic [31:0] mres;   // MEM during EX
    logic        xwe;  logic [4:0] xrd; logic [31:0] xdata;  // WB during EX
    logic [31:0] e_r1, e_r2, e_st;
  } vec_t;

  typedef struct packed {
    logic [4:0]  op, rd;
    logic [31:0] r1, r2, st;
    logic        we, ld;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_alu_op = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
    id_pc = 32'd0; id_src = 2'd0; id_is_load = 1'b0; id_wb_en = 1'b0;
    flush = 1'b0; ex_ready = 1'b1; mem_rd = 5'd0; mem_wb_en = 1'b0;
    mem_res = 32'd0; wb_rd = 5'd0; wb_en = 1'b0; wb_data = 32'd0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic ld, input logic we);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_is_load = ld; id_wb_en = we;
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] src, input logic [31:0] imm, input logic [31:0] pc,
                         input logic ld, input logic we,
                         input logic [31:0] e_r1, input logic [31:0] e_r2, input logic [31:0] e_st);
    vec_t v;
    v = '0;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.d1 = d1; v.d2 = d2;
    v.src = src; v.imm = imm; v.pc = pc; v.ld = ld; v.we = we;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    // ---------------- vector table (forwarding fields patched per entry)
    add_vec(ALU_ADD, 5'd1,  5'd2,  5'd3,  32'h11,   32'h22,   2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'h11,       32'h22,       32'h22);
    add_vec(ALU_SUB, 5'd3,  5'd6,  5'd7,  32'h5,    32'h7,    2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'h10,       32'h7,        32'h7);
    vecs[1].mwe = 1'b1; vecs[1].mrd = 5'd3; vecs[1].mres = 32'h10;
    vecs[1].xwe = 1'b1; vecs[1].xrd = 5'd3; vecs[1].xdata = 32'h20;
    add_vec(ALU_XOR, 5'd0,  5'd5,  5'd8,  32'h99,   32'h55,   2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'h0,        32'h55,       32'h55);
    vecs[2].mwe = 1'b1; vecs[2].mrd = 5'd0; vecs[2].mres = 32'hAA;
    vecs[2].xwe = 1'b1; vecs[2].xrd = 5'd0; vecs[2].xdata = 32'hBB;
    add_vec(ALU_OR,  5'd7,  5'd8,  5'd9,  32'h1,    32'h2,    2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'h1,        32'h80,       32'h80);
    vecs[3].mwe = 1'b1; vecs[3].mrd = 5'd9; vecs[3].mres = 32'h90;
    vecs[3].xwe = 1'b1; vecs[3].xrd = 5'd8; vecs[3].xdata = 32'h80;
    add_vec(ALU_AND, 5'd10, 5'd11, 5'd12, 32'h1,    32'h3,    2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'hCAFE,     32'h3,        32'h3);
    vecs[4].cwe = 1'b1; vecs[4].crd = 5'd10; vecs[4].cdata = 32'hCAFE;
    add_vec(ALU_ADD, 5'd13, 5'd12, 5'd14, 32'h1000, 32'h1234, 2'd1, 32'hFFFFFFFC, 32'h0,          1'b0, 1'b1, 32'h1000,     32'hFFFFFFFC, 32'h4321);
    vecs[5].mwe = 1'b1; vecs[5].mrd = 5'd12; vecs[5].mres = 32'h4321;
    add_vec(ALU_SLL, 5'd14, 5'd15, 5'd16, 32'h5,    32'h6,    2'd2, 32'h0,        32'h80000040,   1'b0, 1'b1, 32'h80000040, 32'h6,        32'h6);
    vecs[6].mwe = 1'b1; vecs[6].mrd = 5'd14; vecs[6].mres = 32'h77;
    add_vec(ALU_ADD, 5'd16, 5'd17, 5'd18, 32'h1,    32'h2,    2'd3, 32'h8,        32'h100,        1'b0, 1'b1, 32'h100,      32'h8,        32'h99);
    vecs[7].xwe = 1'b1; vecs[7].xrd = 5'd17; vecs[7].xdata = 32'h99;
    add_vec(ALU_ADD, 5'd18, 5'd19, 5'd20, 32'h200,  32'h0,    2'd1, 32'h4,        32'h0,          1'b1, 1'b1, 32'h300,      32'h4,        32'h0);
    vecs[8].mwe = 1'b0; vecs[8].mrd = 5'd18; vecs[8].mres = 32'hBAD;
    vecs[8].xwe = 1'b1; vecs[8].xrd = 5'd18; vecs[8].xdata = 32'h300;
    add_vec(ALU_ADD, 5'd21, 5'd22, 5'd0,  32'hA,    32'hB,    2'd1, 32'h10,       32'h0,          1'b0, 1'b0, 32'hA,        32'h10,       32'hD0);
    vecs[9].cwe = 1'b1; vecs[9].crd = 5'd22; vecs[9].cdata = 32'hC0;
    vecs[9].mwe = 1'b1; vecs[9].mrd = 5'd22; vecs[9].mres = 32'hD0;
    add_vec(ALU_REMU, 5'd0, 5'd23, 5'd24, 32'h12,   32'h5,    2'd0, 32'h0,        32'h0,          1'b0, 1'b1, 32'h0,        32'h5,        32'h5);
    vecs[10].cwe = 1'b1; vecs[10].crd = 5'd0; vecs[10].cdata = 32'hEE;

    // ---------------- reset held two cycles with a valid instruction offered
    idle();
    rst = 1'b1;
    drive_id(5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("rst%0d_ex_valid", k), {31'd0, ex_valid}, 32'd0);
      chk($sformatf("rst%0d_ex_r1", k), ex_r1, 32'd0);
      chk($sformatf("rst%0d_ex_r2", k), ex_r2, 32'd0);
      chk($sformatf("rst%0d_ex_wb_en", k), {31'd0, ex_wb_en}, 32'd0);
      chk($sformatf("rst%0d_id_ready", k), {31'd0, id_ready}, 32'd1);
    end
    idle();
    cyc();

    // ---------------- table: capture, then check in EX with forwarding inputs
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      idle();
      drive_id(v.rs1, v.rs2, v.rd, v.d1, v.d2, v.ld, v.we);
      id_alu_op = v.op; id_src = v.src; id_imm = v.imm; id_pc = v.pc;
      wb_en = v.cwe; wb_rd = v.crd; wb_data = v.cdata;
      e.op = v.op; e.rd = v.rd; e.r1 = v.e_r1; e.r2 = v.e_r2; e.st = v.e_st;
      e.we = v.we; e.ld = v.ld;
      sb.push_back(e);
      cyc();
      idle();
      mem_wb_en = v.mwe; mem_rd = v.mrd; mem_res = v.mres;
      wb_en = v.xwe; wb_rd = v.xrd; wb_data = v.xdata;
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_alu_op", i), {27'd0, ex_alu_op}, {27'd0, e.op});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, e.rd});
      chk($sformatf("v%0d_r1", i), ex_r1, e.r1);
      chk($sformatf("v%0d_r2", i), ex_r2, e.r2);
      chk($sformatf("v%0d_store", i), ex_store_data, e.st);
      chk($sformatf("v%0d_wb_en", i), {31'd0, ex_wb_en}, {31'd0, e.we});
      chk($sformatf("v%0d_is_load", i), {31'd0, ex_is_load}, {31'd0, e.ld});
      cyc();
    end

    // ---------------- load-use: stall, bubble, capture, WB forward in EX
    idle();
    drive_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 1'b1, 1'b1);
    id_src = 2'd1;
    cyc();
    idle();
    drive_id(5'd9, 5'd4, 5'd5, 32'h9, 32'hDEAD, 1'b0, 1'b1);
    #1;
    chk("lu_id_ready_low", {31'd0, id_ready}, 32'd0);
    chk("lu_ex_is_load", {31'd0, ex_is_load}, 32'd1);
    cyc();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_wb_en", {31'd0, ex_wb_en}, 32'd0);
    chk("lu_id_ready_high", {31'd0, id_ready}, 32'd1);
    mem_rd = 5'd4; mem_wb_en = 1'b0;
    cyc();
    idle();
    wb_rd = 5'd4; wb_en = 1'b1; wb_data = 32'h4444;
    #1;
    chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cap_rd", {27'd0, ex_rd}, 32'd5);
    chk("lu_cap_r2", ex_r2, 32'h4444);
    cyc();
    // a load to x0 never stalls
    idle();
    drive_id(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc();
    idle();
    drive_id(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("lu_x0_id_ready", {31'd0, id_ready}, 32'd1);
    cyc();
    idle();
    cyc();

    // ---------------- back-pressure: WB retired mid-stall is kept
    drive_id(5'd6, 5'd7, 5'd8, 32'h1, 32'h2, 1'b0, 1'b1);
    cyc();
    idle();
    ex_ready = 1'b0;
    drive_id(5'd25, 5'd26, 5'd27, 32'h3, 32'h4, 1'b0, 1'b1);
    wb_rd = 5'd6; wb_en = 1'b1; wb_data = 32'h77;
    #1;
    chk("st_id_ready", {31'd0, id_ready}, 32'd0);
    chk("st_c1_r1", ex_r1, 32'h77);
    cyc();
    wb_en = 1'b0;
    #1;
    chk("st_c2_r1", ex_r1, 32'h77);
    chk("st_c2_valid", {31'd0, ex_valid}, 32'd1);
    chk("st_c2_rd", {27'd0, ex_rd}, 32'd8);
    cyc();
    chk("st_c3_r1", ex_r1, 32'h77);
    cyc();
    idle();
    #1;
    chk("st_rel_r1", ex_r1, 32'h77);
    chk("st_rel_valid", {31'd0, ex_valid}, 32'd1);
    chk("st_rel_rd", {27'd0, ex_rd}, 32'd8);
    cyc();

    // ---------------- flush kills the instruction being captured
    drive_id(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 1'b0, 1'b1);
    cyc();
    drive_id(5'd3, 5'd4, 5'd10, 32'h3, 32'h4, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_pre_valid", {31'd0, ex_valid}, 32'd1);
    cyc();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_wb_en", {31'd0, ex_wb_en}, 32'd0);
    chk("fl_is_load", {31'd0, ex_is_load}, 32'd0);
    idle();
    cyc();

    // ---------------- reset during a stall discards the held instruction
    drive_id(5'd1, 5'd2, 5'd11, 32'h1, 32'h2, 1'b0, 1'b1);
    cyc();
    ex_ready = 1'b0;
    rst = 1'b1;
    cyc();
    chk("rs_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_wb_en", {31'd0, ex_wb_en}, 32'd0);
    chk("rs_id_ready", {31'd0, id_ready}, 32'd0);
    idle();
    cyc();
    chk("rs_post_valid", {31'd0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
